// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART-to-bus bridge: command/response byte codes,
// the controller state encoding and a ceil(log2) helper for counter widths.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    WDATA  = 3'd2,
    BUS    = 3'd3,
    TX     = 3'd4,
    TXWAIT = 3'd5
  } state_t;

  // Number of bits needed to count 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/uart_bridge_timer.sv
// Loadable down-counter used for the frame and bus timeouts.
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset (reloads LOAD_VAL)
//   i_clear  reload LOAD_VAL (has priority over i_en)
//   i_en     count down by one per cycle, holding at zero
//   o_tc     terminal count: counter is zero
module uart_bridge_timer
  import uart_bridge_pkg::*;
#(
  parameter int LOAD_VAL = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  localparam int W = clog2(LOAD_VAL + 1);
  localparam logic [W-1:0] LOAD = W'(LOAD_VAL);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= LOAD;
    end else if (i_clear) begin
      r_count <= LOAD;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/uart_bus_bridge.sv
// Serial-to-bus initiator: decodes 'W'/'R' frames from the uart receiver,
// performs one word access on the picorv32 native memory interface and
// returns ACK/NAK or the four read-data bytes through the uart transmitter.
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   rx_data, rx_valid           received byte and its one-cycle strobe
//   tx_data, tx_load, tx_busy   byte to send, load strobe, transmitter busy
//   mem_valid/addr/wdata/wstrb  bus request (word address, wstrb F=write)
//   mem_ready, mem_rdata        slave completion strobe and read data
//   busy                        controller not in IDLE
//
// state  | meaning
// IDLE   | wait for a command byte
// ADDR   | collect 4 little-endian address bytes
// WDATA  | collect 4 little-endian write-data bytes ('W' only)
// BUS    | hold mem_valid until mem_ready or bus timeout
// TX     | load the next response byte once the transmitter is free
// TXWAIT | let tx_busy rise, then wait for it to fall
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int FRAME_TIMEOUT = 1200000,
  parameter int BUS_TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_load,
  input  logic        tx_busy,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_cnt;       // frame byte index within ADDR/WDATA
  logic [1:0]  r_rsp_cnt;   // response bytes still to send after the current one
  logic [1:0]  r_wait;      // cycles of tx_busy to ignore after a load
  logic        r_is_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rsp;       // response shift register, byte 0 goes out first

  logic w_frame_clr;
  logic w_frame_en;
  logic w_frame_tc;
  logic w_bus_clr;
  logic w_bus_en;
  logic w_bus_tc;
  logic w_tx_load;

  uart_bridge_timer #(.LOAD_VAL(FRAME_TIMEOUT - 1)) u_frame_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_frame_clr),
    .i_en    (w_frame_en),
    .o_tc    (w_frame_tc)
  );

  uart_bridge_timer #(.LOAD_VAL(BUS_TIMEOUT - 1)) u_bus_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_bus_clr),
    .i_en    (w_bus_en),
    .o_tc    (w_bus_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_tx_load    = 1'b0;
    w_frame_clr  = (r_state == IDLE);
    w_frame_en   = 1'b0;
    // Bus timer is held at its load value outside BUS so it starts counting
    // on the first mem_valid cycle.
    w_bus_clr    = 1'b1;
    w_bus_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) w_next_state = ADDR;
          else                                                 w_next_state = TX;
        end
      end
      ADDR, WDATA: begin
        w_frame_en = 1'b1;
        if (rx_valid) begin
          w_frame_clr = 1'b1;
          if (r_cnt == 2'd3) begin
            if ((r_state == ADDR) && r_is_write) w_next_state = WDATA;
            else                                 w_next_state = BUS;
          end
        end else if (w_frame_tc) begin
          w_next_state = IDLE;
        end
      end
      BUS: begin
        w_bus_clr = 1'b0;
        w_bus_en  = 1'b1;
        // mem_ready wins over a timeout on the same cycle.
        if (mem_ready || w_bus_tc) w_next_state = TX;
      end
      TX: begin
        if (!tx_busy) begin
          w_tx_load    = 1'b1;
          w_next_state = TXWAIT;
        end
      end
      TXWAIT: begin
        if ((r_wait == 2'd0) && !tx_busy) begin
          w_next_state = (r_rsp_cnt == 2'd0) ? IDLE : TX;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= 2'd0;
      r_rsp_cnt  <= 2'd0;
      r_wait     <= 2'd0;
      r_is_write <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_rsp      <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (rx_valid) begin
            r_cnt      <= 2'd0;
            r_is_write <= (rx_data == CMD_WRITE);
            r_rsp      <= {24'h0, RSP_NAK};
            r_rsp_cnt  <= 2'd0;
          end
        end
        ADDR: begin
          if (rx_valid) begin
            r_addr <= {rx_data, r_addr[31:8]};
            r_cnt  <= r_cnt + 2'd1;
          end
        end
        WDATA: begin
          if (rx_valid) begin
            r_wdata <= {rx_data, r_wdata[31:8]};
            r_cnt   <= r_cnt + 2'd1;
          end
        end
        BUS: begin
          if (mem_ready) begin
            if (r_is_write) begin
              r_rsp     <= {24'h0, RSP_ACK};
              r_rsp_cnt <= 2'd0;
            end else begin
              r_rsp     <= mem_rdata;
              r_rsp_cnt <= 2'd3;
            end
          end else if (w_bus_tc) begin
            r_rsp     <= {24'h0, RSP_NAK};
            r_rsp_cnt <= 2'd0;
          end
        end
        TX: begin
          if (!tx_busy) begin
            r_rsp  <= {8'h0, r_rsp[31:8]};
            r_wait <= 2'd2;
          end
        end
        TXWAIT: begin
          if (r_wait != 2'd0) begin
            r_wait <= r_wait - 2'd1;
          end else if (!tx_busy && (r_rsp_cnt != 2'd0)) begin
            r_rsp_cnt <= r_rsp_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_valid = (r_state == BUS);
  assign mem_addr  = r_addr & 32'hFFFF_FFFC;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = (mem_valid && r_is_write) ? 4'hF : 4'h0;
  assign tx_data   = r_rsp[7:0];
  assign tx_load   = w_tx_load;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_bus_bridge.sv
module tb_uart_bus_bridge;

  localparam int FT  = 40;
  localparam int BT  = 16;
  localparam int TXB = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic        tx_busy;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;

  uart_bus_bridge #(.FRAME_TIMEOUT(FT), .BUS_TIMEOUT(BT)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_busy   (tx_busy),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          len;    // expected mem_valid cycles, 0 = not checked
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [7:0]  tx_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  int          slave_lat   = 0;
  bit          slave_mute  = 1'b0;
  logic [31:0] slave_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no event within bound, expected one", name);
  endtask

  task automatic exp_bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int len);
    bus_exp_t e;
    e.addr = a; e.wdata = d; e.wstrb = s; e.len = len;
    bus_q.push_back(e);
  endtask

  task automatic exp_tx(input logic [7:0] b);
    tx_q.push_back(b);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #2;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #2;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d, input bit with_data);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    if (with_data) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) fail_bound(name);
  endtask

  task automatic wait_mem_valid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_valid) begin ok = 1'b1; break; end
    end
    if (!ok) fail_bound(name);
  endtask

  task automatic wait_tx_load(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_load) begin ok = 1'b1; break; end
    end
    if (!ok) fail_bound(name);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_mem_valid"}, {31'h0, mem_valid}, 32'h0);
    check({tag, "_mem_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
    check({tag, "_tx_load"},   {31'h0, tx_load},   32'h0);
    check({tag, "_busy"},      {31'h0, busy},      32'h0);
    check({tag, "_mem_addr"},  mem_addr,           32'h0);
    check({tag, "_mem_wdata"}, mem_wdata,          32'h0);
    check({tag, "_tx_data"},   {24'h0, tx_data},   32'h0);
  endtask

  // Slave: answers mem_valid after slave_lat extra cycles with a 1-cycle mem_ready.
  initial begin
    int vcnt;
    vcnt      = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        vcnt      = 0;
      end else if (mem_valid) begin
        if (!slave_mute && (vcnt == slave_lat)) begin
          mem_ready = 1'b1;
          mem_rdata = slave_rdata;
        end
        vcnt++;
      end else begin
        vcnt = 0;
      end
    end
  end

  // Transmitter: busy for TXB cycles starting the cycle after each load.
  initial begin
    int busy_left;
    busy_left = 0;
    tx_busy   = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_load)            busy_left = TXB;
      else if (busy_left > 0) busy_left--;
      @(posedge clk); #2;
      tx_busy = (busy_left > 0);
    end
  end

  // Monitor: pops the scoreboard on every bus request and every tx_load.
  initial begin
    bus_exp_t cur;
    bit       mv_prev;
    int       len;
    logic [7:0] eb;
    mv_prev = 1'b0;
    len     = 0;
    cur.len = 0;
    forever begin
      @(negedge clk);
      if (mem_valid === 1'b1) begin
        if (!mv_prev) begin
          len = 0;
          if (bus_q.size() == 0) begin
            cur.len = 0;
            n_cmp++;
            n_bad++;
            $display("FAIL bus_unexpected: got request addr %h, expected none", mem_addr);
          end else begin
            cur = bus_q.pop_front();
            check("bus_addr",  mem_addr,            cur.addr);
            check("bus_wstrb", {28'h0, mem_wstrb},  {28'h0, cur.wstrb});
            if (cur.wstrb == 4'hF) check("bus_wdata", mem_wdata, cur.wdata);
          end
        end
        len++;
      end else if (mv_prev && (cur.len != 0)) begin
        check("bus_valid_len", len, cur.len);
      end
      mv_prev = (mem_valid === 1'b1);
      if (tx_load === 1'b1) begin
        check("tx_load_while_busy", {31'h0, tx_busy}, 32'h0);
        if (tx_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected: got byte %h, expected none", tx_data);
        end else begin
          eb = tx_q.pop_front();
          check("tx_byte", {24'h0, tx_data}, {24'h0, eb});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk); #2;
    reset = 1'b0;

    // Write: 57 10 00 00 00 EF BE AD DE
    slave_lat = 2;
    exp_bus(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3);
    exp_tx(8'h06);
    send_frame(8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    wait_idle("write_done");

    // Read: 52 07 01 00 00, low address bits dropped
    slave_lat = 0; slave_rdata = 32'h1234_5678;
    exp_bus(32'h0000_0104, 32'h0, 4'h0, 1);
    exp_tx(8'h78); exp_tx(8'h56); exp_tx(8'h34); exp_tx(8'h12);
    send_frame(8'h52, 32'h0000_0107, 32'h0, 1'b0);
    wait_idle("read_done");

    // Unknown command, then a normal read
    exp_tx(8'h15);
    send_byte(8'h41);
    wait_idle("nak_done");
    slave_lat = 3; slave_rdata = 32'hA5A5_0F0F;
    exp_bus(32'h0000_2000, 32'h0, 4'h0, 4);
    exp_tx(8'h0F); exp_tx(8'h0F); exp_tx(8'hA5); exp_tx(8'hA5);
    send_frame(8'h52, 32'h0000_2000, 32'h0, 1'b0);
    wait_idle("read_after_nak_done");

    // Frame timeout after 'W' + 3 address bytes
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    repeat (FT) @(negedge clk);
    check("ftmo_busy_last_cycle", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("ftmo_busy_after", {31'h0, busy}, 32'h0);
    slave_lat = 1;
    exp_bus(32'h0000_0024, 32'h4433_2211, 4'hF, 2);
    exp_tx(8'h06);
    send_frame(8'h57, 32'h0000_0024, 32'h4433_2211, 1'b1);
    wait_idle("write_after_ftmo_done");

    // Bus timeout with mem_ready held low
    slave_mute = 1'b1;
    exp_bus(32'h0000_0040, 32'h0, 4'h0, BT);
    exp_tx(8'h15);
    send_frame(8'h52, 32'h0000_0040, 32'h0, 1'b0);
    wait_idle("bus_tmo_done");
    slave_mute = 1'b0;

    // mem_ready on the final timeout cycle still succeeds
    slave_lat = BT - 1; slave_rdata = 32'hCAFE_F00D;
    exp_bus(32'h0000_0080, 32'h0, 4'h0, BT);
    exp_tx(8'h0D); exp_tx(8'hF0); exp_tx(8'hFE); exp_tx(8'hCA);
    send_frame(8'h52, 32'h0000_0080, 32'h0, 1'b0);
    wait_idle("bus_last_cycle_done");

    // Stray rx bytes during BUS and TXWAIT are dropped
    slave_lat = 5; slave_rdata = 32'h0BAD_F00D;
    exp_bus(32'h0000_000C, 32'h0, 4'h0, 6);
    exp_tx(8'h0D); exp_tx(8'hF0); exp_tx(8'hAD); exp_tx(8'h0B);
    send_frame(8'h52, 32'h0000_000C, 32'h0, 1'b0);
    wait_mem_valid("junk_wait_bus");
    send_byte(8'h57);
    wait_tx_load("junk_wait_tx");
    send_byte(8'h52);
    wait_idle("junk_done");

    // Reset while mem_valid is high
    slave_mute = 1'b1;
    exp_bus(32'h0000_0050, 32'h0, 4'h0, 0);
    send_frame(8'h52, 32'h0000_0050, 32'h0, 1'b0);
    wait_mem_valid("rst_bus_wait");
    repeat (3) @(negedge clk);
    @(posedge clk); #2; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_cleared("rst_in_bus");
    @(posedge clk); #2; reset = 1'b0;
    slave_mute = 1'b0;

    // Reset during TXWAIT
    slave_lat = 0;
    exp_bus(32'h0000_0060, 32'h0102_0304, 4'hF, 1);
    exp_tx(8'h06);
    send_frame(8'h57, 32'h0000_0060, 32'h0102_0304, 1'b1);
    wait_tx_load("rst_tx_wait");
    @(posedge clk); #2; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_cleared("rst_in_txwait");
    @(posedge clk); #2; reset = 1'b0;
    repeat (TXB + 4) @(posedge clk);

    slave_lat = 2; slave_rdata = 32'h89AB_CDEF;
    exp_bus(32'h0000_0010, 32'h0, 4'h0, 3);
    exp_tx(8'hEF); exp_tx(8'hCD); exp_tx(8'hAB); exp_tx(8'h89);
    send_frame(8'h52, 32'h0000_0010, 32'h0, 1'b0);
    wait_idle("read_after_reset_done");

    repeat (5) @(negedge clk);
    check("bus_queue_left", bus_q.size(), 32'h0);
    check("tx_queue_left",  tx_q.size(),  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
